// File: rtl/uart_hex_rx.sv
// uart_hex_rx: ASCII hex line parser for the debug UART receive path.
// Hex digits accumulate into a WIDTH-bit word; CR or LF publishes it with a
// one-cycle o_data_stb. Invalid characters or too many digits pulse o_err once
// and the rest of the line is discarded up to the next terminator.
//
// Optional feature macro: UART_HEX_RX_BKSP_EN
//   defined   -> BS (0x08) and DEL (0x7F) delete the last entered digit.
//   undefined -> BS and DEL are ordinary invalid characters.
//
// Input handshake: i_rx_valid is a one-cycle qualifier with no ready/backpressure;
// i_rx_data is consumed on every rising edge where i_rx_valid is 1, including
// consecutive cycles. Outputs o_data_stb and o_err are registered pulses that
// appear the cycle after the byte is sampled.
module uart_hex_rx #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_data_stb,
    output logic             o_err,
    output logic             o_busy,
    output logic [1:0]       o_state
);

    localparam int NUM_NIB = WIDTH / 4;
    localparam int CNT_W   = $clog2(NUM_NIB + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic             is_digit;
    logic             is_term;
    logic [3:0]       nib;
    logic [WIDTH+3:0] acc_ext;
    logic [WIDTH-1:0] acc_shift;
    logic             cnt_full;
`ifdef UART_HEX_RX_BKSP_EN
    logic             is_bksp;
`endif

    // Classify the incoming byte and precompute the shifted accumulator.
    always_comb begin
        is_digit = 1'b0;
        nib      = 4'd0;
        if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
            is_digit = 1'b1;
            nib      = i_rx_data[3:0];
        end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                     (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so +9 maps them to 10.
            is_digit = 1'b1;
            nib      = i_rx_data[3:0] + 4'd9;
        end
        is_term   = (i_rx_data == 8'h0D) || (i_rx_data == 8'h0A);
`ifdef UART_HEX_RX_BKSP_EN
        is_bksp   = (i_rx_data == 8'h08) || (i_rx_data == 8'h7F);
`endif
        acc_ext   = {acc, nib};
        acc_shift = acc_ext[WIDTH-1:0];
        cnt_full  = (cnt == CNT_W'(NUM_NIB));
    end

    // Line parser: state, accumulator, published word and output pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            o_data     <= '0;
            o_data_stb <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_data_stb <= 1'b0;
            o_err      <= 1'b0;
            if (i_rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (is_digit) begin
                            acc   <= acc_shift;
                            cnt   <= CNT_W'(1);
                            state <= ST_ACCUM;
                        end else if (is_term) begin
                            // Empty lines and the LF of CR/LF produce nothing.
                            state <= ST_IDLE;
`ifdef UART_HEX_RX_BKSP_EN
                        end else if (is_bksp) begin
                            state <= ST_IDLE;
`endif
                        end else begin
                            o_err <= 1'b1;
                            state <= ST_DISCARD;
                        end
                    end
                    ST_ACCUM: begin
                        if (is_digit) begin
                            if (cnt_full) begin
                                o_err <= 1'b1;
                                state <= ST_DISCARD;
                            end else begin
                                acc <= acc_shift;
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else if (is_term) begin
                            o_data     <= acc;
                            o_data_stb <= 1'b1;
                            acc        <= '0;
                            cnt        <= '0;
                            state      <= ST_IDLE;
`ifdef UART_HEX_RX_BKSP_EN
                        end else if (is_bksp) begin
                            if (cnt > CNT_W'(1)) begin
                                acc <= acc >> 4;
                                cnt <= cnt - CNT_W'(1);
                            end else begin
                                acc   <= '0;
                                cnt   <= '0;
                                state <= ST_IDLE;
                            end
`endif
                        end else begin
                            o_err <= 1'b1;
                            state <= ST_DISCARD;
                        end
                    end
                    ST_DISCARD: begin
                        // Only a terminator ends a bad line; one error per line.
                        if (is_term) begin
                            acc   <= '0;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_state = state;

endmodule

// File: tb/tb_uart_hex_rx.sv
// tb_uart_hex_rx: directed test-plan lines followed by random lines, checked
// cycle by cycle against a line-level reference model (queue of nibbles).
module tb_uart_hex_rx;

  localparam int WIDTH   = 32;
  localparam int NUM_NIB = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic [7:0]       i_rx_data;
  logic             i_rx_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_data_stb;
  logic             o_err;
  logic             o_busy;
  logic [1:0]       o_state;

  uart_hex_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_data     (o_data),
    .o_data_stb (o_data_stb),
    .o_err      (o_err),
    .o_busy     (o_busy),
    .o_state    (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic [3:0]       nib_q[$];
  bit               bad;
  logic [WIDTH-1:0] exp_data;
  int               n_assert;
  int               n_fail;
  int               stb_seen;
  int               err_seen;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int hex_val(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 65 + 10;
    if (b >= "a" && b <= "f") return int'(b) - 97 + 10;
    return -1;
  endfunction

  // Line-level reference: a line is a list of nibbles plus a "bad" mark.
  task automatic model_byte(input logic [7:0] b, output bit m_stb, output bit m_err);
    int               v;
    logic [WIDTH-1:0] word;
    m_stb = 1'b0;
    m_err = 1'b0;
    v = hex_val(b);
    if (b == 8'h0D || b == 8'h0A) begin
      if (!bad && nib_q.size() > 0) begin
        word = '0;
        foreach (nib_q[k]) word = word * 16 + WIDTH'(nib_q[k]);
        exp_q.push_back(word);
        exp_data = word;
        m_stb = 1'b1;
      end
      nib_q.delete();
      bad = 1'b0;
    end else if (v >= 0) begin
      if (!bad) begin
        if (nib_q.size() == NUM_NIB) begin
          bad   = 1'b1;
          m_err = 1'b1;
        end else begin
          nib_q.push_back(4'(v));
        end
      end
`ifdef UART_HEX_RX_BKSP_EN
    end else if (b == 8'h08 || b == 8'h7F) begin
      if (!bad && nib_q.size() > 0) void'(nib_q.pop_back());
`endif
    end else begin
      if (!bad) begin
        bad   = 1'b1;
        m_err = 1'b1;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; drives one cycle and checks outputs at the next negedge.
  task automatic step(input bit valid, input logic [7:0] b);
    bit m_stb, m_err;
    logic [WIDTH-1:0] w;
    i_rx_valid = valid;
    i_rx_data  = b;
    m_stb = 1'b0;
    m_err = 1'b0;
    if (valid) model_byte(b, m_stb, m_err);
    @(negedge clk);
    i_rx_valid = 1'b0;
    check("data_stb", WIDTH'(o_data_stb), WIDTH'(m_stb));
    check("err", WIDTH'(o_err), WIDTH'(m_err));
    check("busy", WIDTH'(o_busy), WIDTH'(bad || nib_q.size() > 0));
    check("data_hold", o_data, exp_data);
    if (o_data_stb === 1'b1) begin
      stb_seen++;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("sb_word", o_data, w);
      end else begin
        check("sb_unexpected_stb", WIDTH'(1), WIDTH'(0));
      end
    end
    if (o_err === 1'b1) err_seen++;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_rx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nib_q.delete();
    bad = 1'b0;
    exp_data = '0;
    exp_q.delete();
    check("rst_data", o_data, '0);
    check("rst_stb", WIDTH'(o_data_stb), '0);
    check("rst_err", WIDTH'(o_err), '0);
    check("rst_busy", WIDTH'(o_busy), '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s0, e0;
    logic [7:0] alphabet[16];
    n_assert = 0;
    n_fail   = 0;
    stb_seen = 0;
    err_seen = 0;
    bad      = 1'b0;
    exp_data = '0;
    rst        = 1'b1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    do_reset();

    // DEADBEEF
    s0 = stb_seen; e0 = err_seen;
    send_str("DEADBEEF\r");
    check("deadbeef_word", o_data, 32'hDEADBEEF);
    check("deadbeef_nstb", stb_seen - s0, 1);
    check("deadbeef_nerr", err_seen - e0, 0);
    check("deadbeef_busy", WIDTH'(o_busy), '0);

    // lowercase, CR/LF pair, empty line
    s0 = stb_seen;
    send_str("1f\r\n\n");
    check("1f_word", o_data, 32'h0000001F);
    check("1f_nstb", stb_seen - s0, 1);

    // overflow on 9th digit, then recovery
    s0 = stb_seen; e0 = err_seen;
    send_str("123456789\r");
    check("ovf_nerr", err_seen - e0, 1);
    check("ovf_nstb", stb_seen - s0, 0);
    send_str("42\n");
    check("42_word", o_data, 32'h00000042);

    // invalid character keeps previous o_data
    s0 = stb_seen; e0 = err_seen;
    send_str("12G4\r");
    check("inv_nerr", err_seen - e0, 1);
    check("inv_nstb", stb_seen - s0, 0);
    check("inv_hold", o_data, 32'h00000042);

    // reset mid-line
    send_str("AB");
    do_reset();
    s0 = stb_seen;
    send_str("5\r");
    check("rst_5_word", o_data, 32'h00000005);
    check("rst_5_nstb", stb_seen - s0, 1);

    // backspace line
    s0 = stb_seen; e0 = err_seen;
    send_str("AB");
    step(1'b1, 8'h08);
    send_str("C\r");
`ifdef UART_HEX_RX_BKSP_EN
    check("bksp_word", o_data, 32'h000000AC);
    check("bksp_nerr", err_seen - e0, 0);
    check("bksp_nstb", stb_seen - s0, 1);
`else
    check("bksp_nerr", err_seen - e0, 1);
    check("bksp_nstb", stb_seen - s0, 0);
    check("bksp_hold", o_data, 32'h00000005);
`endif

    // random lines, mostly back-to-back bytes with occasional gaps/resets
    alphabet = '{"0", "7", "9", "A", "c", "F", "e", "3",
                 8'h0D, 8'h0A, "G", " ", 8'h08, 8'h7F, "b", "5"};
    for (int ln = 0; ln < 300; ln++) begin
      int len;
      len = $urandom_range(0, 11);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 9) < 7) step(1'b1, alphabet[$urandom_range(0, 7) == 0 ?
                                                   $urandom_range(10, 13) :
                                                   ($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(14, 15))]);
        else step(1'b0, 8'($urandom));
      end
      if ($urandom_range(0, 49) == 0) do_reset();
      step(1'b1, $urandom_range(0, 1) ? 8'h0D : 8'h0A);
    end
    step(1'b0, 8'h00);
    check("sb_drained", WIDTH'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_hex_rx.md
# uart_hex_rx

Receive-side ASCII hex command parser for the debug UART. Consumes bytes from the UART receiver's received/rx_byte outputs, accumulates hexadecimal digits into a WIDTH-bit word, and presents the word with a one-cycle strobe when a line terminator (CR or LF) arrives. It is the host-to-fabric counterpart of the hex-dump transmit path, so a terminal can write the same word format the design prints.

## Interface
- WIDTH, 32, word width in bits; must be a multiple of 4; NUM_NIB = WIDTH/4.
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high, sampled on rising edge of clk.
- i_rx_data  input  8  received byte from UART receiver.
- i_rx_valid  input  1  one-cycle qualifier for i_rx_data.
- o_data  output  WIDTH  last completed word; held until next o_data_stb.
- o_data_stb  output  1  one-cycle pulse: o_data updated this cycle.
- o_err  output  1  one-cycle pulse: invalid character or digit overflow.
- o_busy  output  1  high while a line is partially received (state != IDLE).

## Operation
- Character classes: digit '0'-'9' (0x30-0x39) and 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66), all mapping to values 0-15; terminator CR (0x0D) or LF (0x0A); everything else is invalid.
- Accumulator acc[WIDTH-1:0] and nibble counter cnt, range 0..NUM_NIB.
- States:
  - IDLE: acc = 0 and cnt = 0. A digit loads acc = {acc[WIDTH-5:0], nib}, sets cnt = 1, and moves to ACCUM. A terminator is ignored, so empty lines and the LF of a CR/LF pair produce nothing. An invalid character pulses o_err and moves to DISCARD.
  - ACCUM: a digit with cnt < NUM_NIB shifts in and increments cnt. A digit with cnt == NUM_NIB pulses o_err and moves to DISCARD. A terminator loads o_data = acc, pulses o_data_stb, clears acc and cnt, and returns to IDLE. An invalid character pulses o_err and moves to DISCARD.
  - DISCARD: all non-terminators are dropped without further o_err. A terminator clears acc and cnt and returns to IDLE with no strobe.
- Short lines are right-justified and zero-extended. Example: "1F\r" gives 0x0000001F.
- o_err pulses at most once per line.
- The block has no backpressure. The consumer must take o_data on the o_data_stb cycle or later, before the next strobe.

## Timing
- Reset values: o_data = 0, o_data_stb = 0, o_err = 0, o_busy = 0, state = IDLE, acc = 0, cnt = 0.
- Bytes are acted on only in cycles where i_rx_valid = 1.
- o_data_stb and o_err are registered. Each asserts in the cycle after the rising edge that sampled the triggering byte, which is 1-cycle latency, and lasts exactly one cycle.
- o_busy reflects the registered state and rises 1 cycle after the first digit or invalid character.
- Back-to-back i_rx_valid on consecutive cycles must be handled with no lost bytes. The receiver normally spaces bytes by a full character time, but the block does not rely on that.
- A terminator and a new digit on consecutive cycles: the strobe fires for the old line and the digit starts a new line in IDLE.
- rst mid-line discards the partial word. o_data is cleared to 0 and no strobe or error is generated.

## Configuration
- UART_HEX_RX_BKSP_EN defined: backspace (0x08) and DEL (0x7F) are edit characters.
  - In ACCUM with cnt > 1: acc = acc >> 4 and cnt decrements.
  - In ACCUM with cnt == 1: acc is cleared, cnt = 0, and the state returns to IDLE.
  - In IDLE: ignored.
  - In DISCARD: ignored, and the state stays DISCARD.
  - No o_err in any of these cases.
- UART_HEX_RX_BKSP_EN undefined: 0x08 and 0x7F are invalid characters. They pulse o_err and enter DISCARD.

## Test plan
- WIDTH=32, send "DEADBEEF\r" → single o_data_stb with o_data=0xDEADBEEF, o_err never asserted, o_busy low afterwards.
- Send "1f\r\n" then "\n" → exactly one strobe with o_data=0x0000001F; the LF and the empty line produce no strobe.
- Send "123456789\r" → o_err pulses once on the 9th digit, no strobe on CR, then "42\n" → strobe with o_data=0x00000042.
- Send "12G4\r" → o_err pulses 1 cycle after 'G', no strobe, and o_data keeps its previous value.
- Send "AB", assert rst for 1 cycle, then send "5\r" → o_data=0 after reset, then a strobe with o_data=0x00000005.
- With UART_HEX_RX_BKSP_EN defined, send "AB\x08C\r" → o_data=0x000000AC, no o_err. Without the macro, the same input gives an o_err pulse and no strobe.
